// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute states per opcode
// and drives datapath selects and write enables from registered state outputs.
module main_control_fsm #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_J     = 6'h02,
   parameter logic [5:0] OP_ADDI  = 6'h08
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic [1:0] PCSource,
   output logic [1:0] AluOp,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       InstrDone,
   output logic       IllegalOp,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } stateT;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       memtoReg;
      logic       irWrite;
      logic [1:0] pcSource;
      logic [1:0] aluOp;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic       regWrite;
      logic       regDst;
      logic       instrDone;
   } ctrlT;

   stateT      state;
   ctrlT       ctrl;
   logic [5:0] latchedOp;
   logic       illegal;

   function automatic logic isKnownOp(input logic [5:0] op);
      isKnownOp = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                  (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

   function automatic stateT nextOf(input stateT s, input logic [5:0] op,
                                    input logic [5:0] lop);
      nextOf = FETCH;
      case (s)
         FETCH:  nextOf = DECODE;
         DECODE: begin
            if (op == OP_LW || op == OP_SW) nextOf = MEMADR;
            else if (op == OP_RTYPE)        nextOf = EXEC;
            else if (op == OP_BEQ)          nextOf = BRANCH;
            else if (op == OP_J)            nextOf = JUMP;
            else if (op == OP_ADDI)         nextOf = ADDIEX;
            else                            nextOf = FETCH;
         end
         // Live Opcode may already have moved on; only the latched copy is trusted here.
         MEMADR: nextOf = (lop == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  nextOf = MEMWB;
         EXEC:   nextOf = RWB;
         ADDIEX: nextOf = ADDIWB;
         default: nextOf = FETCH;
      endcase
   endfunction

   function automatic ctrlT wordOf(input stateT s);
      wordOf = '0;
      case (s)
         FETCH: begin
            wordOf.memRead  = 1'b1;
            wordOf.irWrite  = 1'b1;
            wordOf.pcWrite  = 1'b1;
            wordOf.aluSrcB  = 2'b01;
         end
         DECODE: wordOf.aluSrcB = 2'b11;
         MEMADR, ADDIEX: begin
            wordOf.aluSrcA = 1'b1;
            wordOf.aluSrcB = 2'b10;
         end
         MEMRD: begin
            wordOf.memRead = 1'b1;
            wordOf.iorD    = 1'b1;
         end
         MEMWB: begin
            wordOf.regWrite  = 1'b1;
            wordOf.memtoReg  = 1'b1;
            wordOf.instrDone = 1'b1;
         end
         MEMWR: begin
            wordOf.memWrite  = 1'b1;
            wordOf.iorD      = 1'b1;
            wordOf.instrDone = 1'b1;
         end
         EXEC: begin
            wordOf.aluSrcA = 1'b1;
            wordOf.aluOp   = 2'b10;
         end
         RWB: begin
            wordOf.regWrite  = 1'b1;
            wordOf.regDst    = 1'b1;
            wordOf.instrDone = 1'b1;
         end
         BRANCH: begin
            wordOf.aluSrcA     = 1'b1;
            wordOf.aluOp       = 2'b01;
            wordOf.pcWriteCond = 1'b1;
            wordOf.pcSource    = 2'b01;
            wordOf.instrDone   = 1'b1;
         end
         JUMP: begin
            wordOf.pcWrite   = 1'b1;
            wordOf.pcSource  = 2'b10;
            wordOf.instrDone = 1'b1;
         end
         ADDIWB: begin
            wordOf.regWrite  = 1'b1;
            wordOf.instrDone = 1'b1;
         end
         default: wordOf = '0;
      endcase
   endfunction

   // Control word is registered alongside the state, so it is a pure function of the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FETCH;
         ctrl      <= wordOf(FETCH);
         latchedOp <= '0;
         illegal   <= 1'b0;
      end else begin
         state <= nextOf(state, Opcode, latchedOp);
         ctrl  <= wordOf(nextOf(state, Opcode, latchedOp));
         if (state == DECODE) begin
            latchedOp <= Opcode;
            if (!isKnownOp(Opcode)) illegal <= 1'b1;
         end
      end
   end

   assign PCWrite     = ctrl.pcWrite;
   assign PCWriteCond = ctrl.pcWriteCond;
   assign IorD        = ctrl.iorD;
   assign MemRead     = ctrl.memRead;
   assign MemWrite    = ctrl.memWrite;
   assign MemtoReg    = ctrl.memtoReg;
   assign IRWrite     = ctrl.irWrite;
   assign PCSource    = ctrl.pcSource;
   assign AluOp       = ctrl.aluOp;
   assign AluSrcA     = ctrl.aluSrcA;
   assign AluSrcB     = ctrl.aluSrcB;
   assign RegWrite    = ctrl.regWrite;
   assign RegDst      = ctrl.regDst;
   assign InstrDone   = ctrl.instrDone;
   assign IllegalOp   = illegal;
   assign State       = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed table-driven bench for main_control_fsm plus per-opcode latency and
// write-enable exclusivity sequences.
module tb_main_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic [1:0] PCSource, AluOp, AluSrcB;
   logic       AluSrcA, RegWrite, RegDst, InstrDone, IllegalOp;
   logic [3:0] State;

   main_control_fsm dut (
      .clk(clk), .reset(reset), .Opcode(Opcode),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCSource(PCSource), .AluOp(AluOp),
      .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .RegWrite(RegWrite),
      .RegDst(RegDst), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
      .State(State)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,AluOp,AluSrcA,AluSrcB,RegWrite,RegDst,InstrDone}
   localparam logic [16:0] W_FETCH  = 17'b1_0_0_1_0_0_1_00_00_0_01_0_0_0;
   localparam logic [16:0] W_DECODE = 17'b0_0_0_0_0_0_0_00_00_0_11_0_0_0;
   localparam logic [16:0] W_MEMADR = 17'b0_0_0_0_0_0_0_00_00_1_10_0_0_0;
   localparam logic [16:0] W_MEMRD  = 17'b0_0_1_1_0_0_0_00_00_0_00_0_0_0;
   localparam logic [16:0] W_MEMWB  = 17'b0_0_0_0_0_1_0_00_00_0_00_1_0_1;
   localparam logic [16:0] W_MEMWR  = 17'b0_0_1_0_1_0_0_00_00_0_00_0_0_1;
   localparam logic [16:0] W_EXEC   = 17'b0_0_0_0_0_0_0_00_10_1_00_0_0_0;
   localparam logic [16:0] W_RWB    = 17'b0_0_0_0_0_0_0_00_00_0_00_1_1_1;
   localparam logic [16:0] W_BRANCH = 17'b0_1_0_0_0_0_0_01_01_1_00_0_0_1;
   localparam logic [16:0] W_JUMP   = 17'b1_0_0_0_0_0_0_10_00_0_00_0_0_1;
   localparam logic [16:0] W_ADDIEX = 17'b0_0_0_0_0_0_0_00_00_1_10_0_0_0;
   localparam logic [16:0] W_ADDIWB = 17'b0_0_0_0_0_0_0_00_00_0_00_1_0_1;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [16:0] word;
      logic        ill;
   } vecT;

   vecT vecs[$];
   int  tests = 0;
   int  fails = 0;

   function automatic logic [16:0] actualWord();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
              PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst, InstrDone};
   endfunction

   task automatic add(input logic r, input logic [5:0] op, input logic [3:0] st,
                      input logic [16:0] w, input logic ill);
      vecT v;
      v.rst = r; v.op = op; v.st = st; v.word = w; v.ill = ill;
      vecs.push_back(v);
   endtask

   task automatic latency(input logic [5:0] op, input int expN);
      int n;
      logic [4:0] we;
      logic ok;
      n = 0;
      Opcode = op;
      do begin
         n++;
         @(posedge clk); #1;
         we = {MemWrite, RegWrite, PCWrite, PCWriteCond, IRWrite};
         ok = ($countones(we) <= 1) || (State == 4'd0 && we == 5'b00101);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL wen_excl op=%h state=%0d enables=%b required at most one (or PCWrite+IRWrite in FETCH)",
                     op, State, we);
         end
      end while (State != 4'd0 && n < 12);
      tests++;
      if (n != expN) begin
         fails++;
         $display("FAIL latency op=%h got %0d cycles required %0d", op, n, expN);
      end
   endtask

   initial begin
      reset  = 1'b1;
      Opcode = 6'h00;

      // reset, release
      add(1, 6'h00, 4'd0, W_FETCH,  0);
      add(1, 6'h00, 4'd0, W_FETCH,  0);
      // lw, opcode switched to sw while in MEMADR
      add(0, 6'h23, 4'd1, W_DECODE, 0);
      add(0, 6'h23, 4'd2, W_MEMADR, 0);
      add(0, 6'h2B, 4'd3, W_MEMRD,  0);
      add(0, 6'h2B, 4'd4, W_MEMWB,  0);
      add(0, 6'h2B, 4'd0, W_FETCH,  0);
      // R-type
      add(0, 6'h00, 4'd1, W_DECODE, 0);
      add(0, 6'h00, 4'd6, W_EXEC,   0);
      add(0, 6'h00, 4'd7, W_RWB,    0);
      add(0, 6'h00, 4'd0, W_FETCH,  0);
      // sw, opcode switched to lw while in MEMADR
      add(0, 6'h2B, 4'd1, W_DECODE, 0);
      add(0, 6'h2B, 4'd2, W_MEMADR, 0);
      add(0, 6'h23, 4'd5, W_MEMWR,  0);
      add(0, 6'h23, 4'd0, W_FETCH,  0);
      // beq
      add(0, 6'h04, 4'd1, W_DECODE, 0);
      add(0, 6'h04, 4'd8, W_BRANCH, 0);
      add(0, 6'h04, 4'd0, W_FETCH,  0);
      // j
      add(0, 6'h02, 4'd1, W_DECODE, 0);
      add(0, 6'h02, 4'd9, W_JUMP,   0);
      add(0, 6'h02, 4'd0, W_FETCH,  0);
      // addi
      add(0, 6'h08, 4'd1,  W_DECODE, 0);
      add(0, 6'h08, 4'd10, W_ADDIEX, 0);
      add(0, 6'h08, 4'd11, W_ADDIWB, 0);
      add(0, 6'h08, 4'd0,  W_FETCH,  0);
      // illegal opcode, sticky through a following lw
      add(0, 6'h3F, 4'd1, W_DECODE, 0);
      add(0, 6'h3F, 4'd0, W_FETCH,  1);
      add(0, 6'h23, 4'd1, W_DECODE, 1);
      add(0, 6'h23, 4'd2, W_MEMADR, 1);
      add(0, 6'h23, 4'd3, W_MEMRD,  1);
      add(0, 6'h23, 4'd4, W_MEMWB,  1);
      add(0, 6'h23, 4'd0, W_FETCH,  1);
      add(1, 6'h23, 4'd0, W_FETCH,  0);
      // reset in MEMRD of lw aborts the writeback
      add(0, 6'h23, 4'd1, W_DECODE, 0);
      add(0, 6'h23, 4'd2, W_MEMADR, 0);
      add(0, 6'h23, 4'd3, W_MEMRD,  0);
      add(1, 6'h23, 4'd0, W_FETCH,  0);
      add(0, 6'h23, 4'd1, W_DECODE, 0);
      // reset in DECODE
      add(1, 6'h23, 4'd0, W_FETCH,  0);
      add(0, 6'h00, 4'd1, W_DECODE, 0);
      add(0, 6'h00, 4'd6, W_EXEC,   0);
      add(0, 6'h00, 4'd7, W_RWB,    0);
      add(0, 6'h00, 4'd0, W_FETCH,  0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset  = vecs[i].rst;
         Opcode = vecs[i].op;
         @(posedge clk); #1;
         tests++;
         if (State != vecs[i].st || actualWord() != vecs[i].word ||
             IllegalOp != vecs[i].ill) begin
            fails++;
            $display("FAIL vec%0d state=%0d word=%b ill=%b required state=%0d word=%b ill=%b",
                     i, State, actualWord(), IllegalOp, vecs[i].st, vecs[i].word, vecs[i].ill);
         end
      end

      // Now in FETCH: per-opcode latency, FETCH through last state inclusive.
      reset = 1'b0;
      latency(6'h23, 5);
      latency(6'h2B, 4);
      latency(6'h00, 4);
      latency(6'h08, 4);
      latency(6'h04, 3);
      latency(6'h02, 3);
      latency(6'h15, 2);

      tests++;
      if (IllegalOp !== 1'b1) begin
         fails++;
         $display("FAIL illegal_sticky got %b required 1", IllegalOp);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (IllegalOp !== 1'b0 || State !== 4'd0) begin
         fails++;
         $display("FAIL illegal_clear ill=%b state=%0d required ill=0 state=0", IllegalOp, State);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
